// File: rtl/fetch_unit.sv
`default_nettype none
// =============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch controller feeding a halfword prefetch buffer.
//            Halfword (compressed) support is enabled by FETCH_COMPRESSED_EN.
// Revision : 1.0
// =============================================================================
module fetch_unit #(
    parameter int unsigned BUF_WORDS       = 4,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    output logic                                imem_req,
    output logic [31:0]                         imem_addr,
    input  logic                                imem_gnt,
    input  logic                                imem_rvalid,
    input  logic [31:0]                         imem_rdata,
    output logic                                buf_write_en,
    output logic [31:0]                         buf_wdata,
    output logic                                buf_flush,
    output logic                                buf_start_half,
    input  logic [1:0]                          consume,
    output logic [$clog2(2*BUF_WORDS+1)-1:0]    hw_avail,
    input  logic                                redirect,
    input  logic [31:0]                         redirect_pc
);

    localparam int unsigned c_cnt_w = $clog2(2*BUF_WORDS+1);
    localparam logic [c_cnt_w:0] c_buf_words = (c_cnt_w+1)'(BUF_WORDS);
    localparam logic [1:0]       c_max_out   = 2'(MAX_OUTSTANDING);
`ifdef FETCH_COMPRESSED_EN
    localparam logic c_comp = 1'b1;
`else
    localparam logic c_comp = 1'b0;
`endif

    typedef enum logic [1:0] {
        RESET_IDLE = 2'd0,
        FETCH      = 2'd1,
        DRAIN      = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [c_cnt_w-1:0]   hw_cnt_q, hw_cnt_d;
    logic                 rd_par_q, rd_par_d;
    logic                 skip_q, skip_d;
    logic [1:0]           outst_q, outst_d;
    logic [1:0]           discard_q, discard_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          hold_addr_q, hold_addr_d;
    logic                 pending_q, pending_d;
    logic                 flush_q, flush_d;
    logic                 start_half_q, start_half_d;

    logic [1:0]           w_cons_n, w_cons_amt;
    logic                 w_cons_bad;
    logic [c_cnt_w:0]     w_slots, w_used;
    logic                 w_can_issue, w_launch, w_hs, w_keep;
    logic [c_cnt_w-1:0]   w_hw_add, w_cons_ext;
    logic                 w_unused_pc0;

    assign w_unused_pc0 = redirect_pc[0];

    // Decode consume; a request beyond what is buffered is dropped entirely.
    assign w_cons_n   = (consume == 2'b11) ? 2'd2 :
                        ((consume == 2'b10) && c_comp) ? 2'd1 : 2'd0;
    assign w_cons_bad = ((consume == 2'b10) && !c_comp) ||
                        ({{(c_cnt_w-2){1'b0}}, w_cons_n} > hw_cnt_q);
    assign w_cons_amt = (redirect || w_cons_bad) ? 2'd0 : w_cons_n;
    assign w_cons_ext = {{(c_cnt_w-2){1'b0}}, w_cons_amt};

    // Word slots occupied, counting a partially consumed word as a full slot.
    assign w_slots = ({1'b0, hw_cnt_q} + {{c_cnt_w{1'b0}}, rd_par_q}
                      + {{c_cnt_w{1'b0}}, 1'b1}) >> 1;
    assign w_used  = w_slots + {{(c_cnt_w-1){1'b0}}, outst_q};

    assign w_can_issue = (state_q != RESET_IDLE) && (w_used < c_buf_words) &&
                         (outst_q < c_max_out);
    assign imem_req    = pending_q | (w_can_issue & ~redirect);
    assign imem_addr   = pending_q ? hold_addr_q : pc_q;
    assign w_launch    = imem_req & ~pending_q;
    assign w_hs        = imem_req & imem_gnt;

    assign w_keep       = imem_rvalid && (discard_q == 2'd0) && !redirect;
    assign buf_write_en = w_keep;
    assign buf_wdata    = imem_rdata;
    assign w_hw_add     = !w_keep ? '0 :
                          skip_q  ? {{(c_cnt_w-1){1'b0}}, 1'b1} :
                                    {{(c_cnt_w-2){1'b0}}, 2'b10};

    assign buf_flush      = flush_q;
    assign buf_start_half = start_half_q;
    assign hw_avail       = hw_cnt_q;

    always_comb begin
        state_d      = state_q;
        rd_par_d     = rd_par_q;
        skip_d       = skip_q;
        outst_d      = outst_q + {1'b0, w_hs} - {1'b0, imem_rvalid};
        discard_d    = discard_q;
        pc_d         = pc_q;
        hold_addr_d  = hold_addr_q;
        pending_d    = imem_req & ~imem_gnt;
        flush_d      = redirect;
        start_half_d = redirect & c_comp & redirect_pc[1];

        if (w_launch) begin
            hold_addr_d = pc_q;
            pc_d        = pc_q + 32'd4;
        end
        if (imem_rvalid && (discard_q != 2'd0)) begin
            discard_d = discard_q - 2'd1;
        end
        if (w_keep) begin
            skip_d = 1'b0;
        end
        hw_cnt_d = hw_cnt_q - w_cons_ext + w_hw_add;
        if (w_cons_amt == 2'd1) begin
            rd_par_d = ~rd_par_q;
        end

        case (state_q)
            RESET_IDLE: state_d = FETCH;
            DRAIN:      if (discard_d == 2'd0) state_d = FETCH;
            default:    state_d = state_q;
        endcase

        // Everything in flight, including an ungranted request, becomes stale.
        if (redirect) begin
            hw_cnt_d  = '0;
            rd_par_d  = c_comp & redirect_pc[1];
            skip_d    = c_comp & redirect_pc[1];
            discard_d = outst_d + {1'b0, pending_d};
            pc_d      = {redirect_pc[31:2], 2'b00};
            state_d   = (discard_d != 2'd0) ? DRAIN : FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_IDLE;
            hw_cnt_q     <= '0;
            rd_par_q     <= 1'b0;
            skip_q       <= 1'b0;
            outst_q      <= 2'd0;
            discard_q    <= 2'd0;
            pc_q         <= RESET_PC;
            hold_addr_q  <= RESET_PC;
            pending_q    <= 1'b0;
            flush_q      <= 1'b0;
            start_half_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hw_cnt_q     <= hw_cnt_d;
            rd_par_q     <= rd_par_d;
            skip_q       <= skip_d;
            outst_q      <= outst_d;
            discard_q    <= discard_d;
            pc_q         <= pc_d;
            hold_addr_q  <= hold_addr_d;
            pending_q    <= pending_d;
            flush_q      <= flush_d;
            start_half_q <= start_half_d;
        end
    end

    a_consume_legal: assert property (@(posedge clk) disable iff (!rst_n)
                                      !(w_cons_bad && !redirect));

endmodule
`default_nettype wire
